// File: rtl/slurm16_pkg.sv
// Shared constants and types for the slurm16 memory subsystem.
package slurm16_pkg;

    localparam int unsigned BITS         = 16;
    localparam int unsigned ADDRESS_BITS = 16;

    // Fixed master assignment on the main memory arbiter
    localparam int unsigned PORT_CPU   = 0;
    localparam int unsigned PORT_GFX   = 1;
    localparam int unsigned PORT_AUDIO = 2;
    localparam int unsigned PORT_FLASH = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRespond = 2'd2
    } state_e;

endpackage

// File: rtl/slurm16_rr_select.sv
// Round-robin picker: first valid port after last_grant_i, wrapping modulo N_PORTS.
module slurm16_rr_select #(
    parameter int unsigned N_PORTS = 4
) (
    input  logic [N_PORTS-1:0] valid_i,
    input  logic [1:0]         last_grant_i,
    output logic               found_o,
    output logic [1:0]         index_o
);

    logic [3:0] valid_pad;
    logic [1:0] idx;
    logic       hit;
    logic [1:0] hit_idx;

    // Scan ports last_grant+1 .. last_grant+N_PORTS; unused upper ports stay zero
    always_comb begin
        valid_pad = 4'(valid_i);
        idx       = 2'd0;
        hit       = 1'b0;
        hit_idx   = 2'd0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            idx = 2'((32'(last_grant_i) + k) % N_PORTS);
            if (!hit && valid_pad[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
        found_o = hit;
        index_o = hit_idx;
    end

endmodule

// File: rtl/slurm16_memory_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between up to four masters.
module slurm16_memory_arbiter
    import slurm16_pkg::*;
#(
    parameter int unsigned BITS         = slurm16_pkg::BITS,
    parameter int unsigned ADDRESS_BITS = slurm16_pkg::ADDRESS_BITS,
    parameter int unsigned N_PORTS      = 4
) (
    input  logic                            CLK,
    input  logic                            RSTb,
    input  logic [N_PORTS-1:0]              req_valid,
    input  logic [N_PORTS-1:0]              req_wr,
    input  logic [N_PORTS*ADDRESS_BITS-1:0] req_address,
    input  logic [N_PORTS*BITS-1:0]         req_data,
    output logic [N_PORTS-1:0]              req_ready,
    output logic [BITS-1:0]                 rdata,
    output logic [ADDRESS_BITS-1:0]         mem_address,
    output logic [BITS-1:0]                 mem_wdata,
    output logic                            mem_en,
    output logic                            mem_wr,
    input  logic [BITS-1:0]                 mem_rdata,
    output logic                            busy
);

    state_e               state_q, state_d;
    logic [1:0]           grant_q, last_grant_q;
    logic                 grant_latch;
    logic [N_PORTS-1:0]   ready_q, ready_d;
    logic [N_PORTS-1:0]   grant_onehot;
    logic [N_PORTS-1:0]   cand_valid;
    logic                 sel_found;
    logic [1:0]           sel_index;
    logic [3:0]           wr_pad;

    // Candidate set: the master being acknowledged in RESPOND may not win again
    always_comb begin
        grant_onehot = N_PORTS'(1) << grant_q;
        cand_valid   = (state_q == StRespond) ? (req_valid & ~grant_onehot) : req_valid;
    end

    slurm16_rr_select #(
        .N_PORTS (N_PORTS)
    ) u_rr_select (
        .valid_i      (cand_valid),
        .last_grant_i (last_grant_q),
        .found_o      (sel_found),
        .index_o      (sel_index)
    );

    // State, grant and ready registers
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q      <= StIdle;
            grant_q      <= 2'(PORT_CPU);
            last_grant_q <= 2'(N_PORTS - 1);
            ready_q      <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            if (grant_latch) begin
                grant_q      <= sel_index;
                last_grant_q <= sel_index;
            end
        end
    end

    // Next-state logic; ready is loaded while leaving ACCESS so it is high in RESPOND
    always_comb begin
        state_d     = state_q;
        grant_latch = 1'b0;
        ready_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d     = StAccess;
                    grant_latch = 1'b1;
                end
            end
            StAccess: begin
                state_d = StRespond;
                ready_d = grant_onehot;
            end
            StRespond: begin
                if (sel_found) begin
                    state_d     = StAccess;
                    grant_latch = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side mux from the grant register; read data is a straight pass-through
    always_comb begin
        wr_pad      = 4'(req_wr);
        mem_en      = (state_q == StAccess);
        mem_wr      = mem_en & wr_pad[grant_q];
        busy        = (state_q != StIdle);
        mem_address = req_address[int'(grant_q) * ADDRESS_BITS +: ADDRESS_BITS];
        mem_wdata   = req_data[int'(grant_q) * BITS +: BITS];
        rdata       = mem_rdata;
    end

    assign req_ready = ready_q;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Bench for slurm16_memory_arbiter: memory model, scoreboard of expected acknowledgements.
module tb_slurm16_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic [3:0]  req_valid, req_wr, req_ready;
    logic [63:0] req_address, req_data;
    logic [15:0] rdata, mem_address, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, busy;

    logic        pl_en;
    logic [15:0] pl_addr, pl_data;
    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;
    int remaining [4];

    typedef struct packed {
        logic [3:0]  rdy;
        logic        wr;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    slurm16_memory_arbiter #(
        .BITS         (16),
        .ADDRESS_BITS (16),
        .N_PORTS      (4)
    ) dut (
        .CLK         (CLK),
        .RSTb        (RSTb),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_address (req_address),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rdata       (rdata),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    // Synchronous-read memory macro plus a bench preload port
    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_en) begin
            if (mem_wr) mem[mem_address] <= mem_wdata;
            else        mem_rdata <= mem[mem_address];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Scoreboard: every ready pulse pops the next expected acknowledgement
    always @(negedge CLK) begin
        if (req_ready !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ready", 32'(req_ready), 32'd0);
            end else begin : pop
                exp_t e;
                e = exp_q.pop_front();
                check_eq("ready_port", 32'(req_ready), 32'(e.rdy));
                if (!e.wr) check_eq("rdata", 32'(rdata), 32'(e.data));
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task automatic drive(input int p, input logic wr, input logic [15:0] a, input logic [15:0] d);
        req_valid[p]         = 1'b1;
        req_wr[p]            = wr;
        req_address[p*16+:16] = a;
        req_data[p*16+:16]    = d;
    endtask

    task automatic expect_ack(input int p, input logic wr, input logic [15:0] d);
        exp_t e;
        e.rdy  = 4'b0001 << p;
        e.wr   = wr;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        RSTb      = 1'b0;
        req_valid = '0;
        @(negedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
    endtask

    // Masters drop (or re-issue) their request on ready; bounded wait for all to finish
    task automatic run_until_idle(input int max_cycles, input bit chk_gap);
        int  cyc  = 0;
        int  last = -1;
        bit  done = 1'b0;
        while (!done && cyc < max_cycles) begin
            @(negedge CLK);
            cyc++;
            if (req_ready != 4'b0000) begin
                if (chk_gap && last >= 0) check_eq("ready_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                for (int p = 0; p < 4; p++) begin
                    if (req_ready[p]) begin
                        if (remaining[p] > 0) begin
                            remaining[p]--;
                            req_address[p*16+:16] = req_address[p*16+:16] + 16'h0010;
                        end else begin
                            req_valid[p] = 1'b0;
                        end
                    end
                end
            end
            if (chk_gap && req_valid != 4'b0000) check_eq("busy_cont", 32'(busy), 32'd1);
            if (req_valid == 4'b0000) done = 1'b1;
        end
        if (!done) check_eq("timeout", 32'd0, 32'd1);
        @(negedge CLK);
        check_eq("back_to_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        RSTb        = 1'b0;
        req_valid   = '0;
        req_wr      = '0;
        req_address = '0;
        req_data    = '0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        for (int p = 0; p < 4; p++) remaining[p] = 0;

        preload(16'h1234, 16'hBEEF);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                preload(16'(16'h0100 + 16 * r + p), 16'(16'hA000 + 16 * r + p));
        preload(16'h0200, 16'h1111);
        preload(16'h0301, 16'h2222);

        // Reset state; memory address follows port 0 while idle
        req_address[15:0] = 16'hCAFE;
        @(negedge CLK);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_address), 32'hCAFE);
        RSTb = 1'b1;

        // Single CPU read: ACCESS next cycle, ready the cycle after
        drive(0, 1'b0, 16'h1234, 16'h0000);
        expect_ack(0, 1'b0, 16'hBEEF);
        @(negedge CLK);
        check_eq("t1_mem_en", 32'(mem_en), 32'd1);
        check_eq("t1_mem_addr", 32'(mem_address), 32'h1234);
        check_eq("t1_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_no_early_ready", 32'(req_ready), 32'd0);
        @(negedge CLK);
        check_eq("t1_ready", 32'(req_ready), 32'b0001);
        check_eq("t1_mem_en_off", 32'(mem_en), 32'd0);
        req_valid[0] = 1'b0;
        @(negedge CLK);
        check_eq("t1_idle", 32'(busy), 32'd0);
        check_eq("t1_ready_pulse", 32'(req_ready), 32'd0);

        // Port 2 write, then CPU reads it back
        drive(2, 1'b1, 16'h0010, 16'h5A5A);
        expect_ack(2, 1'b1, 16'h0000);
        @(negedge CLK);
        check_eq("t2_mem_en", 32'(mem_en), 32'd1);
        check_eq("t2_mem_wr", 32'(mem_wr), 32'd1);
        check_eq("t2_mem_addr", 32'(mem_address), 32'h0010);
        check_eq("t2_mem_wdata", 32'(mem_wdata), 32'h5A5A);
        @(negedge CLK);
        check_eq("t2_ready", 32'(req_ready), 32'b0100);
        req_valid[2] = 1'b0;
        @(negedge CLK);
        drive(0, 1'b0, 16'h0010, 16'h0000);
        expect_ack(0, 1'b0, 16'h5A5A);
        run_until_idle(10, 1'b0);

        // All four masters continuously from reset: 0,1,2,3,0,1,2,3 back to back
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            remaining[p] = 1;
            drive(p, 1'b0, 16'(16'h0100 + p), 16'h0000);
        end
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                expect_ack(p, 1'b0, 16'(16'hA000 + 16 * r + p));
        run_until_idle(40, 1'b1);

        // last_grant = 1 with ports 1 and 3 pending: port 3 wins first
        apply_reset();
        drive(1, 1'b0, 16'h0200, 16'h0000);
        expect_ack(1, 1'b0, 16'h1111);
        run_until_idle(10, 1'b0);
        drive(1, 1'b0, 16'h0301, 16'h0000);
        drive(3, 1'b1, 16'h0300, 16'h3333);
        expect_ack(3, 1'b1, 16'h0000);
        expect_ack(1, 1'b0, 16'h2222);
        run_until_idle(10, 1'b0);

        // Reset in the middle of an access: no ready, then port 0 wins afresh
        drive(2, 1'b0, 16'h0010, 16'h0000);
        @(negedge CLK);
        check_eq("t5_access", 32'(mem_en), 32'd1);
        #2;
        RSTb = 1'b0;
        #1;
        check_eq("t5_mem_en_drop", 32'(mem_en), 32'd0);
        check_eq("t5_busy_drop", 32'(busy), 32'd0);
        check_eq("t5_mem_wr_drop", 32'(mem_wr), 32'd0);
        check_eq("t5_ready_drop", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge CLK);
        check_eq("t5_no_ready", 32'(req_ready), 32'd0);
        RSTb = 1'b1;
        @(negedge CLK);
        check_eq("t5_idle", 32'(busy), 32'd0);
        drive(0, 1'b0, 16'h0300, 16'h0000);
        drive(1, 1'b0, 16'h1234, 16'h0000);
        expect_ack(0, 1'b0, 16'h3333);
        expect_ack(1, 1'b0, 16'hBEEF);
        run_until_idle(10, 1'b0);

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slurm16_memory_arbiter.md
# slurm16_memory_arbiter

Shares the single-port 16-bit main memory between up to four bus masters (port 0 = CPU memory interface; ports 1–3 = GFX, audio and flash DMA). Each master raises a valid/address/write request and holds it until a one-cycle ready pulse. Grants are round-robin, one access at a time. The block sits between the masters and the synchronous-read memory macro (BRAM/SPRAM) at the top level.

## Interface
Parameters:
- BITS, 16, data width
- ADDRESS_BITS, 16, address width
- N_PORTS, 4, number of masters (2–4); the grant index is 2 bits

Ports:
- CLK  in  1  system clock
- RSTb  in  1  asynchronous active-low reset
- req_valid  in  N_PORTS  per-master request; held until that master's ready
- req_wr  in  N_PORTS  per-master write flag (1 = write)
- req_address  in  N_PORTS*ADDRESS_BITS  flattened addresses; master i at [i*ADDRESS_BITS +: ADDRESS_BITS]
- req_data  in  N_PORTS*BITS  flattened write data, same packing
- req_ready  out  N_PORTS  one-hot, one-cycle completion pulse
- rdata  out  BITS  read data, broadcast to all masters; meaningful only in the cycle the master's ready is high
- mem_address  out  ADDRESS_BITS  to memory macro
- mem_wdata  out  BITS  to memory macro
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write enable
- mem_rdata  in  BITS  memory read data; valid one cycle after an mem_en read
- busy  out  1  high while in ACCESS or RESPOND

## Operation
- FSM states:
  - IDLE: no grant held.
  - ACCESS: mem_en = 1. The granted master's address, data and wr drive the memory.
  - RESPOND: req_ready[grant] = 1 and rdata = mem_rdata.
- IDLE → ACCESS when any req_valid is set. Grant is latched into the grant register on this edge.
- ACCESS → RESPOND unconditionally.
- RESPOND → ACCESS when any req_valid is set, excluding the master being acknowledged this cycle. Otherwise RESPOND → IDLE.
- Round-robin selection:
  - Search starts at last_grant+1 and wraps modulo N_PORTS.
  - The first valid master found wins. last_grant updates when the grant is latched.
  - Reset value of last_grant is N_PORTS-1, so port 0 (CPU) wins the first contest.
- The memory side is a combinational mux from the grant register and the request buses. No request-side registers.
- req_ready is registered and asserts only in RESPOND.
- rdata is combinational pass-through of mem_rdata. Writes also pulse ready in RESPOND; rdata is don't-care for writes.
- Protocol violation (master drops valid during ACCESS): the access still completes with the values currently on its buses, and ready still pulses. No abort.
- A master that re-asserts valid the cycle after its ready is a new request. It competes normally with the others.
- Out-of-range ports (index ≥ N_PORTS) are never granted.

## Timing
- Reset values: state = IDLE, grant = 0, last_grant = N_PORTS-1, req_ready = 0, mem_en = 0, mem_wr = 0, busy = 0. mem_address and mem_wdata follow grant 0's buses and are ignored while mem_en = 0.
- Latency:
  - valid seen at edge T (idle) → ACCESS in cycle T+1 → ready in cycle T+2.
  - Minimum 2 cycles request-to-ready.
- Throughput: one access per 2 cycles with continuous demand (ACCESS/RESPOND alternating, no IDLE gap).
- Fairness: with all N masters requesting continuously, each is served once per 2*N cycles. Worst-case wait is 2*N cycles.
- Simultaneous events:
  - Masters requesting in the same cycle are resolved by round-robin only.
  - Master i's ready and master j's new grant occur in the same RESPOND cycle.
- Reset asserted mid-access:
  - All outputs go to reset values immediately (asynchronous).
  - The in-flight access is dropped and no ready is issued.
  - Masters must re-request after reset.

## Structure
- Shared package `slurm16_pkg`: BITS, ADDRESS_BITS, the FSM state encoding (IDLE = 0, ACCESS = 1, RESPOND = 2) and the port index constants (PORT_CPU = 0, PORT_GFX = 1, PORT_AUDIO = 2, PORT_FLASH = 3).
- One sub-module: `slurm16_rr_select`. It is combinational, takes valid[N_PORTS] and last_grant, and returns found and index. It is reusable for the port-bus arbiter.

## Test plan
- Single CPU read, address 0x1234, memory preloaded 0xBEEF → mem_en high in cycle T+1 with mem_address 0x1234 and mem_wr = 0; req_ready = 4'b0001 and rdata = 0xBEEF in T+2.
- Write from port 2, address 0x0010, data 0x5A5A → mem_wr = 1 in T+1, ready[2] in T+2. A subsequent port-0 read of 0x0010 returns 0x5A5A.
- All four ports valid continuously from reset → grant order 0,1,2,3,0,…. One ready every 2 cycles, no IDLE between them.
- Ports 1 and 3 valid, last_grant = 1 → port 3 granted first, then port 1.
- RSTb pulsed low during ACCESS → req_ready stays 0, mem_en drops immediately, and state is IDLE after release. The next request is granted to port 0.
- N_PORTS = 2 build with ports 2/3 inputs tied high → only ports 0 and 1 are ever granted.
